// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode/funct, ALU and mux codes for the multi-cycle controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_R_EXEC,
    S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;

  localparam logic [4:0] RA_INDEX = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_SLT   = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_DATA1  = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - maps FSM ALU request and R-type funct to the ALU control code
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [5:0] funct,
  output logic [2:0] ALUCtrl
);

  // Fixed operations come straight from aluOp; R-type defers to funct, unknown funct adds
  always_comb begin
    ALUCtrl = ALU_ADD;
    case (aluOp)
      ALUOP_ADD: ALUCtrl = ALU_ADD;
      ALUOP_SUB: ALUCtrl = ALU_SUB;
      ALUOP_SLT: ALUCtrl = ALU_SLT;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  ALUCtrl = ALU_ADD;
          FN_SUB:  ALUCtrl = ALU_SUB;
          FN_AND:  ALUCtrl = ALU_AND;
          FN_OR:   ALUCtrl = ALU_OR;
          FN_SLT:  ALUCtrl = ALU_SLT;
          default: ALUCtrl = ALU_ADD;
        endcase
      end
      default: ALUCtrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multi-cycle MIPS main control FSM
module mips_mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcLoad,
  output logic [1:0] pcSrc,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IRWrite,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic       regWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtrl
);

  state_t     state, state_next;
  logic [1:0] aluOp;

  mips_alu_decoder u_alu_dec (
    .aluOp   (aluOp),
    .funct   (funct),
    .ALUCtrl (ALUCtrl)
  );

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Sequencing: DECODE dispatches on opcode, every final step returns to FETCH
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_next = S_MEM_ADDR;
          OP_RTYPE:         state_next = (funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_ADDI, OP_SLTI: state_next = S_I_EXEC;
          OP_BEQ, OP_BNE:   state_next = S_BRANCH;
          OP_J:             state_next = S_JUMP;
          OP_JAL:           state_next = S_JAL;
          default:          state_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: state_next = S_MEM_WB;
      S_R_EXEC:   state_next = S_R_WB;
      S_I_EXEC:   state_next = S_I_WB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Moore strobes per state; only the branch pcLoad looks at the zero flag
  always_comb begin
    pcLoad   = 1'b0;
    pcSrc    = PCSRC_ALU;
    IorD     = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    IRWrite  = 1'b0;
    regDst   = REGDST_RT;
    memToReg = M2R_ALUOUT;
    regWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REG;
    aluOp    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        memRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        pcLoad  = 1'b1;
      end
      S_DECODE:   ALUSrcB = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        regWrite = 1'b1;
        memToReg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        memWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        aluOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        regWrite = 1'b1;
        regDst   = REGDST_RD;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        aluOp   = (opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
      end
      S_I_WB: regWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        aluOp   = ALUOP_SUB;
        pcSrc   = PCSRC_ALUOUT;
        pcLoad  = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pcSrc  = PCSRC_JUMP;
        pcLoad = 1'b1;
      end
      S_JR: begin
        pcSrc  = PCSRC_DATA1;
        pcLoad = 1'b1;
      end
      S_JAL: begin
        regWrite = 1'b1;
        regDst   = REGDST_RA;
        memToReg = M2R_PC;
        pcSrc    = PCSRC_JUMP;
        pcLoad   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
